// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI master sequencer: frame commands, widths
// and FSM state encoding.
package spi_cmd_pkg;

    localparam int FRAME_W   = 10;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 8;
    localparam int IDX_W     = 4;
    localparam int CAP_IDX_W = 3;

    typedef enum logic [1:0] {
        CMD_WA = 2'b00,
        CMD_WD = 2'b01,
        CMD_RA = 2'b10,
        CMD_RD = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        CMD,
        SHIFT,
        RD_WAIT,
        CAPTURE,
        GAP,
        DONE
    } state_e;

    function automatic logic [FRAME_W-1:0] make_frame(input cmd_e cmd,
                                                      input logic [DATA_W-1:0] payload);
        return {cmd, payload};
    endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// Frame shifter: 10-bit parallel-in word presented one bit at a time by index,
// plus an 8-bit LSB-first capture register for returned read data.
module spi_frame_shifter
    import spi_cmd_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_word,
    input  logic               shift_en,
    input  logic               cap_en,
    input  logic               clear,
    input  logic               miso,
    output logic               cmd_bit,
    output logic               tx_bit,
    output logic               last_bit,
    output logic               last_cap,
    output logic [DATA_W-1:0]  cap_data
);

    localparam logic [IDX_W-1:0]     BIT_END  = IDX_W'(FRAME_W);
    localparam logic [CAP_IDX_W-1:0] CAP_LAST = CAP_IDX_W'(DATA_W - 1);

    logic [FRAME_W-1:0]   word;
    logic [IDX_W-1:0]     bit_idx;
    logic [CAP_IDX_W-1:0] cap_idx;

    always_ff @(posedge clk) begin
        if (load) begin
            word <= load_word;
        end
        if (cap_en) begin
            cap_data[cap_idx] <= miso;
        end
    end

    // bit_idx names the bit MOSI will carry after the next edge, so it runs one ahead
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= '0;
            cap_idx <= '0;
        end else begin
            if (load || clear) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (load || clear) begin
                cap_idx <= '0;
            end else if (cap_en) begin
                cap_idx <= cap_idx + 1'b1;
            end
        end
    end

    assign cmd_bit  = word[FRAME_W-1];
    assign tx_bit   = (bit_idx < BIT_END) ? word[bit_idx] : 1'b0;
    assign last_bit = (bit_idx == BIT_END);
    assign last_cap = (cap_idx == CAP_LAST);

endmodule

// File: rtl/spi_master_seq.sv
// SPI master sequencer: turns one host read/write request into the WA/WD or
// RA/RD frame sequence and returns the captured byte for reads.
module spi_master_seq
    import spi_cmd_pkg::*;
#(
    parameter int GAP_CYC = 2,
    parameter int RD_LAT  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rnw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RD_LAT - 1);

    state_e             state, next_state;
    logic               rnw_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               second_q, second_d;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_inc;
    logic               ss_n_d, mosi_d, rdata_upd;
    logic               load, shift_en, cap_en, clear;
    logic [FRAME_W-1:0] load_word;
    logic               cmd_bit, tx_bit, last_bit, last_cap;
    logic [DATA_W-1:0]  cap_data;

    spi_frame_shifter u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_word(load_word),
        .shift_en (shift_en),
        .cap_en   (cap_en),
        .clear    (clear),
        .miso     (MISO),
        .cmd_bit  (cmd_bit),
        .tx_bit   (tx_bit),
        .last_bit (last_bit),
        .last_cap (last_cap),
        .cap_data (cap_data)
    );

    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            rnw_q   <= req_rnw;
            wdata_q <= req_wdata;
        end
    end

    // SS_n/MOSI are loaded with the values of the state being entered, so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            second_q  <= 1'b0;
            cnt       <= '0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state    <= next_state;
            second_q <= second_d;
            cnt      <= cnt_inc ? cnt + 1'b1 : '0;
            SS_n     <= ss_n_d;
            MOSI     <= mosi_d;
            if (rdata_upd) begin
                rsp_rdata <= rnw_q ? cap_data : '0;
            end
        end
    end

    always_comb begin
        next_state = state;
        second_d   = second_q;
        ss_n_d     = 1'b1;
        mosi_d     = 1'b0;
        load       = 1'b0;
        load_word  = make_frame(CMD_WA, req_addr);
        shift_en   = 1'b0;
        cap_en     = 1'b0;
        clear      = 1'b0;
        cnt_inc    = 1'b0;
        rdata_upd  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    load       = 1'b1;
                    load_word  = make_frame(req_rnw ? CMD_RA : CMD_WA, req_addr);
                    second_d   = 1'b0;
                    next_state = SEL;
                    ss_n_d     = 1'b0;
                end
            end
            SEL: begin
                next_state = CMD;
                ss_n_d     = 1'b0;
                mosi_d     = cmd_bit;
            end
            CMD: begin
                next_state = SHIFT;
                ss_n_d     = 1'b0;
                mosi_d     = tx_bit;
                shift_en   = 1'b1;
            end
            SHIFT: begin
                if (last_bit) begin
                    if (second_q && rnw_q) begin
                        next_state = RD_WAIT;
                        ss_n_d     = 1'b0;
                    end else begin
                        next_state = GAP;
                    end
                end else begin
                    ss_n_d   = 1'b0;
                    mosi_d   = tx_bit;
                    shift_en = 1'b1;
                end
            end
            RD_WAIT: begin
                ss_n_d = 1'b0;
                if (cnt == LAT_LAST) begin
                    next_state = CAPTURE;
                    clear      = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            CAPTURE: begin
                cap_en = 1'b1;
                if (last_cap) begin
                    next_state = GAP;
                end else begin
                    ss_n_d = 1'b0;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    if (!second_q) begin
                        load       = 1'b1;
                        load_word  = rnw_q ? make_frame(CMD_RD, '0) : make_frame(CMD_WD, wdata_q);
                        second_d   = 1'b1;
                        next_state = SEL;
                        ss_n_d     = 1'b0;
                    end else begin
                        next_state = DONE;
                        rdata_upd  = 1'b1;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE) && (state != DONE);

endmodule

// File: tb/tb_spi_master_seq.sv
// Bench for spi_master_seq: table of host operations checked through a frame and
// response scoreboard, plus reset, back-to-back, input-change and parameter cases.
module tb_spi_master_seq;

    localparam int GAP1 = 2;
    localparam int LAT1 = 3;
    localparam int GAP2 = 1;
    localparam int LAT2 = 5;

    typedef struct {
        logic       rnw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] miso_byte;
        logic [7:0] exp_rdata;
        int         exp_lat;
    } vec_t;

    typedef struct {
        logic [7:0] rdata;
        int         lat;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_n;
    logic       req_valid, req_ready, req_rnw, rsp_valid, busy, ss_n, mosi, miso;
    logic [7:0] req_addr, req_wdata, rsp_rdata;
    logic       req_valid2, req_ready2, req_rnw2, rsp_valid2, busy2, ss2_n, mosi2, miso2;
    logic [7:0] req_addr2, req_wdata2, rsp_rdata2;

    spi_master_seq #(.GAP_CYC(GAP1), .RD_LAT(LAT1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_rnw(req_rnw), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .SS_n(ss_n), .MOSI(mosi), .MISO(miso)
    );

    spi_master_seq #(.GAP_CYC(GAP2), .RD_LAT(LAT2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_rnw(req_rnw2), .req_addr(req_addr2), .req_wdata(req_wdata2),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .busy(busy2),
        .SS_n(ss2_n), .MOSI(mosi2), .MISO(miso2)
    );

    int          checks = 0;
    int          errors = 0;
    int          rsp_seen = 0;
    logic [7:0]  miso_byte = 8'h00;
    logic [7:0]  miso2_byte = 8'hFF;
    logic [9:0]  exp_frames[$];
    rsp_t        rsp_q[$];
    int          acc_q[$];
    vec_t        vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave-side monitor: collects MOSI frames, drives MISO during capture, scores responses
    initial begin
        int          nb;
        int          gap_cnt;
        int          a;
        int          exp_len;
        logic [31:0] bits;
        logic [9:0]  w, ew;
        rsp_t        r;
        nb = 0; gap_cnt = 100; bits = '0; miso = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                nb = 0; gap_cnt = 100; miso = 1'b0;
                acc_q.delete();
            end else begin
                if (req_valid && req_ready) acc_q.push_back(cyc);
                if (ss_n == 1'b0) begin
                    if (nb == 0) chk("gap_len", 32'(gap_cnt >= GAP1), 1);
                    if (nb >= 12 + LAT1 && nb < 20 + LAT1) miso = miso_byte[nb - 12 - LAT1];
                    else miso = 1'($urandom_range(0, 1));
                    if (nb < 32) bits[nb] = mosi;
                    nb++;
                    gap_cnt = 0;
                end else begin
                    if (nb != 0) begin
                        w = bits[11:2];
                        if (exp_frames.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_frame actual=%h required=none", w);
                        end else begin
                            ew = exp_frames.pop_front();
                            exp_len = (ew[9:8] == 2'b11) ? 20 + LAT1 : 12;
                            chk("frame_word", w, ew);
                            chk("sel_bit", bits[0], 0);
                            chk("cmd_bit", bits[1], ew[9]);
                            chk("frame_len", nb, exp_len);
                        end
                    end
                    nb = 0;
                    gap_cnt++;
                    chk("mosi_idle", mosi, 0);
                    miso = 1'($urandom_range(0, 1));
                end
                if (rsp_valid) begin
                    if (rsp_q.size() == 0 || acc_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_rsp actual=%h required=none", rsp_rdata);
                    end else begin
                        r = rsp_q.pop_front();
                        a = acc_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, r.rdata);
                        chk("rsp_latency", cyc - a, r.lat);
                    end
                    rsp_seen++;
                end
            end
        end
    end

    // MISO source for the second instance
    initial begin
        int n2;
        n2 = 0; miso2 = 1'b0;
        forever begin
            @(negedge clk);
            if (ss2_n == 1'b0) begin
                if (n2 >= 12 + LAT2 && n2 < 20 + LAT2) miso2 = miso2_byte[n2 - 12 - LAT2];
                else miso2 = 1'($urandom_range(0, 1));
                n2++;
            end else begin
                n2 = 0;
                miso2 = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic push_exp(input logic rnw, input logic [7:0] addr, input logic [7:0] wdata,
                            input logic [7:0] exp_rdata, input int exp_lat);
        rsp_t r;
        if (rnw) begin
            exp_frames.push_back({2'b10, addr});
            exp_frames.push_back({2'b11, 8'h00});
        end else begin
            exp_frames.push_back({2'b00, addr});
            exp_frames.push_back({2'b01, wdata});
        end
        r.rdata = exp_rdata;
        r.lat   = exp_lat;
        rsp_q.push_back(r);
    endtask

    task automatic start_op(input logic rnw, input logic [7:0] addr, input logic [7:0] wdata);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_rnw = rnw; req_addr = addr; req_wdata = wdata;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (req_ready) begin got = 1'b1; break; end
        end
        chk("accepted", got, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        for (int t = 0; t < budget && rsp_seen < target; t++) @(negedge clk);
        chk("rsp_arrived", 32'(rsp_seen >= target), 1);
        chk("frames_drained", exp_frames.size(), 0);
    endtask

    task automatic op2(input logic rnw, input logic [7:0] addr, input logic [7:0] wdata,
                       input logic [7:0] exp_rdata, input int exp_lat);
        int acc, done;
        acc = -1000; done = -1;
        @(posedge clk); #1;
        req_valid2 = 1'b1; req_rnw2 = rnw; req_addr2 = addr; req_wdata2 = wdata;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (req_ready2) begin acc = cyc; break; end
        end
        @(posedge clk); #1;
        req_valid2 = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (rsp_valid2) begin done = cyc; break; end
        end
        chk("p2_latency", done - acc, exp_lat);
        chk("p2_rdata", rsp_rdata2, exp_rdata);
    endtask

    initial begin
        int base, n_acc, a1, a2, done_c;
        rst_n = 1'b0;
        req_valid = 1'b0; req_rnw = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
        req_valid2 = 1'b0; req_rnw2 = 1'b0; req_addr2 = 8'h00; req_wdata2 = 8'h00;

        vecs[0] = '{1'b0, 8'h3C, 8'hA5, 8'h00, 8'h00, 29};
        vecs[1] = '{1'b1, 8'h10, 8'h00, 8'h5A, 8'h5A, 40};
        vecs[2] = '{1'b0, 8'hFF, 8'h00, 8'h00, 8'h00, 29};
        vecs[3] = '{1'b1, 8'h00, 8'h99, 8'hFF, 8'hFF, 40};
        vecs[4] = '{1'b1, 8'h80, 8'h00, 8'h00, 8'h00, 40};
        vecs[5] = '{1'b1, 8'hE1, 8'h00, 8'hC3, 8'hC3, 40};

        repeat (3) @(negedge clk);
        chk("rst_ss_n", ss_n, 1);
        chk("rst_mosi", mosi, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            base = rsp_seen;
            miso_byte = vecs[i].miso_byte;
            push_exp(vecs[i].rnw, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_lat);
            start_op(vecs[i].rnw, vecs[i].addr, vecs[i].wdata);
            @(negedge clk);
            chk("busy_mid", busy, 1);
            chk("ready_mid", req_ready, 0);
            wait_rsp(base + 1, 80);
        end

        // Host inputs change while busy: frames must keep the latched request
        base = rsp_seen;
        push_exp(1'b0, 8'h3C, 8'hA5, 8'h00, 29);
        start_op(1'b0, 8'h3C, 8'hA5);
        repeat (3) @(posedge clk);
        #1;
        req_addr = 8'h77; req_wdata = 8'h11; req_rnw = 1'b1;
        wait_rsp(base + 1, 80);

        // req_valid held high: second accept lands the cycle after DONE
        base = rsp_seen;
        push_exp(1'b0, 8'h21, 8'h42, 8'h00, 29);
        push_exp(1'b0, 8'h21, 8'h42, 8'h00, 29);
        n_acc = 0; a1 = -1; a2 = -1; done_c = -1000;
        @(posedge clk); #1;
        req_valid = 1'b1; req_rnw = 1'b0; req_addr = 8'h21; req_wdata = 8'h42;
        for (int t = 0; t < 120 && n_acc < 2; t++) begin
            @(negedge clk);
            if (rsp_valid && done_c < 0) done_c = cyc;
            if (req_valid && req_ready) begin
                n_acc++;
                if (n_acc == 1) a1 = cyc; else a2 = cyc;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("held_accepts", n_acc, 2);
        chk("held_reaccept", a2 - done_c, 1);
        chk("held_spacing", a2 - a1, 30);
        wait_rsp(base + 2, 80);

        // Asynchronous reset in the middle of SHIFT
        base = rsp_seen;
        start_op(1'b0, 8'hFF, 8'hFF);
        repeat (5) @(negedge clk);
        chk("pre_rst_mosi", mosi, 1);
        chk("pre_rst_ss_n", ss_n, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ss_n", ss_n, 1);
        chk("arst_mosi", mosi, 0);
        chk("arst_busy", busy, 0);
        chk("arst_req_ready", req_ready, 1);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_rsp_rdata", rsp_rdata, 0);
        exp_frames.delete();
        rsp_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_ss_n", ss_n, 1);
        repeat (40) @(negedge clk);
        chk("post_rst_no_rsp", rsp_seen, base);
        chk("post_rst_idle", busy, 0);

        // Second instance: GAP_CYC=1, RD_LAT=5
        miso2_byte = 8'hFF;
        op2(1'b1, 8'h42, 8'h00, 8'hFF, 40);
        op2(1'b0, 8'h42, 8'h5A, 8'h00, 27);
        miso2_byte = 8'h96;
        op2(1'b1, 8'h07, 8'h00, 8'h96, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
